// File: rtl/sprite_bounce_ctrl.sv
// ---------------------------------------------------------------------------
// sprite_bounce_ctrl
//
// Screen-saver controller that drives a black-and-white image ROM.
//   * A small motion FSM moves the sprite's top-left corner by STEP pixels per
//     axis once every FRAMES_PER_MOVE frames. When a step would push the sprite
//     past an active-display edge, the sprite reverses direction instead.
//   * Raster coordinates are turned into image-relative ROM addresses.
//   * The ROM's registered pixel is gated to the sprite window, giving a fixed
//     3-cycle latency from px_x/px_y to pixel_out.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   enable          1 = motion enabled, 0 = position frozen (rendering goes on)
//   px_x, px_y      raster coordinates from the timing generator
//   px_active       raster is inside the active area
//   frame_tick      one-cycle pulse at the start of vertical blanking
//   x_img, y_img    registered ROM address, 8'hFF outside the sprite window
//   pixel_in        ROM pixel, one cycle after the address
//   pixel_out       sprite pixel, raster + 3 cycles
//   pos_x, pos_y    sprite top-left corner
//   dir_x, dir_y    0 = right/down, 1 = left/up
// ---------------------------------------------------------------------------
module sprite_bounce_ctrl #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned IMG_W           = 21,
  parameter int unsigned IMG_H           = 230,
  parameter int unsigned STEP            = 1,
  parameter int unsigned FRAMES_PER_MOVE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] px_x,
  input  logic [9:0] px_y,
  input  logic       px_active,
  input  logic       frame_tick,
  output logic [7:0] x_img,
  output logic [7:0] y_img,
  input  logic       pixel_in,
  output logic       pixel_out,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       dir_x,
  output logic       dir_y
);

  localparam int unsigned CNT_W = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_MOVE - 1);

  localparam logic [10:0] H_ACT_11 = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_11 = 11'(V_ACTIVE);
  localparam logic [10:0] IMG_W_11 = 11'(IMG_W);
  localparam logic [10:0] IMG_H_11 = 11'(IMG_H);
  localparam logic [10:0] STEP_11  = 11'(STEP);
  localparam logic [9:0]  STEP_10  = 10'(STEP);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_COUNT  = 2'd1,
    S_MOVE_X = 2'd2,
    S_MOVE_Y = 2'd3
  } state_e;

  // One axis of motion. Returns {new_dir, new_pos}. The edge test is done in
  // 11 bits so pos + extent + STEP cannot wrap; the position itself always
  // stays inside 10 bits because of the bounce.
  function automatic logic [10:0] axis_step(input logic [9:0]  pos,
                                            input logic        dir,
                                            input logic [10:0] extent,
                                            input logic [10:0] limit);
    logic [10:0] res;
    if (!dir) begin
      if (({1'b0, pos} + extent + STEP_11) > limit) res = {1'b1, pos - STEP_10};
      else                                          res = {1'b0, pos + STEP_10};
    end else begin
      if ({1'b0, pos} < STEP_11) res = {1'b0, pos + STEP_10};
      else                       res = {1'b1, pos - STEP_10};
    end
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [10:0]      step_x_s, step_y_s;

  logic             win_s;
  logic [7:0]       x_img_d, y_img_d;
  logic [7:0]       x_img_q, y_img_q;
  logic             win_q, win_d2_q, pixel_out_q;

  assign step_x_s = axis_step(pos_x_q, dir_x_q, IMG_W_11, H_ACT_11);
  assign step_y_s = axis_step(pos_y_q, dir_y_q, IMG_H_11, V_ACT_11);

  // Motion FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_WAIT;
    else       state_q <= state_d;
  end

  // Motion FSM next-state logic; ticks seen outside WAIT are simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: begin
        if (frame_tick && enable) state_d = S_COUNT;
        else                      state_d = S_WAIT;
      end
      S_COUNT: begin
        if (cnt_q == CNT_LAST) state_d = S_MOVE_X;
        else                   state_d = S_WAIT;
      end
      S_MOVE_X: state_d = S_MOVE_Y;
      S_MOVE_Y: state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase
  end

  // Motion FSM outputs: frame counter and per-axis position/direction updates.
  always_comb begin
    cnt_d   = cnt_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    case (state_q)
      S_COUNT: begin
        if (cnt_q == CNT_LAST) cnt_d = '0;
        else                   cnt_d = cnt_q + CNT_W'(1);
      end
      S_MOVE_X: begin
        dir_x_d = step_x_s[10];
        pos_x_d = step_x_s[9:0];
      end
      S_MOVE_Y: begin
        dir_y_d = step_y_s[10];
        pos_y_d = step_y_s[9:0];
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Motion datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      pos_x_q <= 10'd0;
      pos_y_q <= 10'd0;
      dir_x_q <= 1'b0;
      dir_y_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
    end
  end

  // Sprite window test and image-relative address. Only the low 8 bits of the
  // offset are needed, and they are the same whether the subtraction is done
  // in 8 or 10 bits.
  always_comb begin
    win_s = px_active
          && (px_x >= pos_x_q) && ({1'b0, px_x} < ({1'b0, pos_x_q} + IMG_W_11))
          && (px_y >= pos_y_q) && ({1'b0, px_y} < ({1'b0, pos_y_q} + IMG_H_11));
    if (win_s) begin
      x_img_d = px_x[7:0] - pos_x_q[7:0];
      y_img_d = px_y[7:0] - pos_y_q[7:0];
    end else begin
      x_img_d = 8'hFF;
      y_img_d = 8'hFF;
    end
  end

  // Address/pixel pipeline: stage 1 address, stage 2 is the ROM register
  // (window flag delayed alongside), stage 3 gated pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_img_q     <= 8'hFF;
      y_img_q     <= 8'hFF;
      win_q       <= 1'b0;
      win_d2_q    <= 1'b0;
      pixel_out_q <= 1'b0;
    end else begin
      x_img_q     <= x_img_d;
      y_img_q     <= y_img_d;
      win_q       <= win_s;
      win_d2_q    <= win_q;
      pixel_out_q <= pixel_in & win_d2_q;
    end
  end

  assign x_img     = x_img_q;
  assign y_img     = y_img_q;
  assign pixel_out = pixel_out_q;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign dir_x     = dir_x_q;
  assign dir_y     = dir_y_q;

endmodule

// File: tb/tb_sprite_bounce_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sprite_bounce_ctrl
//
// Self-checking bench for sprite_bounce_ctrl. A behavioural model tracks the
// sprite as plain integers (accepted ticks, moves, bounce by reversal) and an
// image ROM model returns pixels; expected addresses and pixels come from the
// model's sprite position and a 3-deep delay line.
// ---------------------------------------------------------------------------
module tb_sprite_bounce_ctrl;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int IMG_W    = 21;
  localparam int IMG_H    = 230;
  localparam int STEP     = 1;
  localparam int FPM      = 2;

  logic       clk = 1'b0;
  logic       reset, enable, px_active, frame_tick, pixel_in;
  logic [9:0] px_x, px_y, pos_x, pos_y;
  logic [7:0] x_img, y_img;
  logic       pixel_out, dir_x, dir_y;

  int checks   = 0;
  int failures = 0;

  // Model state
  int m_pos_x = 0, m_pos_y = 0;
  bit m_dir_x = 0, m_dir_y = 0;
  int m_acc = 0, m_busy = 0, m_moves = 0;
  int e_x_img = 255, e_y_img = 255;
  bit e1 = 0, e2 = 0, e3 = 0;

  always #5 clk = ~clk;

  sprite_bounce_ctrl #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .STEP(STEP), .FRAMES_PER_MOVE(FPM)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .px_x(px_x), .px_y(px_y),
    .px_active(px_active), .frame_tick(frame_tick), .x_img(x_img), .y_img(y_img),
    .pixel_in(pixel_in), .pixel_out(pixel_out), .pos_x(pos_x), .pos_y(pos_y),
    .dir_x(dir_x), .dir_y(dir_y)
  );

  // Image ROM content: 0 outside the image, a fixed pattern inside.
  function automatic bit rom_px(input int x, input int y);
    if (x >= IMG_W || y >= IMG_H) return 1'b0;
    return ((x + 2 * y) % 3) != 0;
  endfunction

  // One axis moves STEP in its direction; a step leaving [0, maxp] reverses.
  function automatic void move_axis(inout int p, inout bit d, input int maxp);
    int cand;
    cand = d ? p - STEP : p + STEP;
    if (cand < 0 || cand > maxp) begin
      d = !d;
      p = d ? p - STEP : p + STEP;
    end else begin
      p = cand;
    end
  endfunction

  // Drive one clock cycle of inputs, advance the model, sample #1 after edge.
  task automatic cyc(input bit rst, input bit tick, input bit en,
                     input bit act, input int x, input int y);
    bit rom_v, win;
    reset = rst; frame_tick = tick; enable = en; px_active = act;
    px_x = x[9:0]; px_y = y[9:0];
    rom_v = rom_px(int'(x_img), int'(y_img));
    win = act && x >= m_pos_x && x < m_pos_x + IMG_W && y >= m_pos_y && y < m_pos_y + IMG_H;
    if (rst) begin
      e_x_img = 255; e_y_img = 255; e1 = 0; e2 = 0; e3 = 0;
      m_pos_x = 0; m_pos_y = 0; m_dir_x = 0; m_dir_y = 0; m_acc = 0; m_busy = 0;
    end else begin
      e_x_img = win ? x - m_pos_x : 255;
      e_y_img = win ? y - m_pos_y : 255;
      e3 = e2; e2 = e1;
      e1 = win && rom_px(x - m_pos_x, y - m_pos_y);
      if (m_busy > 0) m_busy--;
      else if (tick && en) begin
        m_acc++;
        if (m_acc % FPM == 0) begin
          move_axis(m_pos_x, m_dir_x, H_ACTIVE - IMG_W);
          move_axis(m_pos_y, m_dir_y, V_ACTIVE - IMG_H);
          m_moves++;
          m_busy = 3;
        end else begin
          m_busy = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    pixel_in = rom_v;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic settle();
    for (int k = 0; k < 4; k++) if (m_busy > 0) cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_reset();
    pixel_in = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    checks++; if (pos_x !== 10'd0 || pos_y !== 10'd0) begin failures++; $display("FAIL reset_pos got=(%0d,%0d) exp=(0,0)", pos_x, pos_y); end
    checks++; if (dir_x !== 1'b0 || dir_y !== 1'b0) begin failures++; $display("FAIL reset_dir got=(%0d,%0d) exp=(0,0)", dir_x, dir_y); end
    checks++; if (x_img !== 8'hFF || y_img !== 8'hFF) begin failures++; $display("FAIL reset_img got=(%0h,%0h) exp=(ff,ff)", x_img, y_img); end
    checks++; if (pixel_out !== 1'b0) begin failures++; $display("FAIL reset_pixel got=%0d exp=0", pixel_out); end
  endtask

  task automatic test_address_map();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 5, 7);
    checks++; if (x_img !== 8'd5 || y_img !== 8'd7) begin failures++; $display("FAIL addr_5_7 got=(%0d,%0d) exp=(5,7)", x_img, y_img); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 21, 7);
    checks++; if (x_img !== 8'hFF || y_img !== 8'hFF) begin failures++; $display("FAIL addr_21_7 got=(%0h,%0h) exp=(ff,ff)", x_img, y_img); end
    checks++; if (pixel_out !== 1'b0) begin failures++; $display("FAIL pix_early got=%0d exp=0", pixel_out); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    checks++; if (pixel_out !== 1'b1) begin failures++; $display("FAIL pix_lat3 got=%0d exp=1", pixel_out); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    checks++; if (pixel_out !== 1'b0) begin failures++; $display("FAIL pix_outside got=%0d exp=0", pixel_out); end
  endtask

  task automatic test_motion_rate();
    repeat (4) begin cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 0); idle(4); end
    checks++; if (pos_x !== 10'd2 || pos_y !== 10'd2) begin failures++; $display("FAIL rate_pos got=(%0d,%0d) exp=(2,2)", pos_x, pos_y); end
    repeat (4) begin cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0); idle(4); end
    checks++; if (pos_x !== 10'd2 || pos_y !== 10'd2) begin failures++; $display("FAIL frozen_pos got=(%0d,%0d) exp=(2,2)", pos_x, pos_y); end
  endtask

  task automatic test_bounce_random();
    int iter = 0;
    int prev = 0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    m_moves = 0;
    while (m_moves < 1240 && iter < 40000) begin
      iter++;
      cyc(1'b0, 1'b1, ($urandom_range(0, 9) != 0), 1'b0, 0, 0);
      repeat ($urandom_range(0, 4)) cyc(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) != 0), 1'b0, 0, 0);
      settle();
      checks++; if (int'(pos_x) !== m_pos_x || int'(pos_y) !== m_pos_y) begin failures++; $display("FAIL move_pos got=(%0d,%0d) exp=(%0d,%0d)", pos_x, pos_y, m_pos_x, m_pos_y); end
      checks++; if (dir_x !== m_dir_x || dir_y !== m_dir_y) begin failures++; $display("FAIL move_dir got=(%0d,%0d) exp=(%0d,%0d)", dir_x, dir_y, m_dir_x, m_dir_y); end
      checks++; if (int'(pos_x) > H_ACTIVE - IMG_W || int'(pos_y) > V_ACTIVE - IMG_H) begin failures++; $display("FAIL bounds got=(%0d,%0d) max=(%0d,%0d)", pos_x, pos_y, H_ACTIVE - IMG_W, V_ACTIVE - IMG_H); end
      if (m_moves != prev) begin
        prev = m_moves;
        case (m_moves)
          251: begin checks++; if (pos_y !== 10'd249 || dir_y !== 1'b1) begin failures++; $display("FAIL bottom_bounce got=(%0d,%0d) exp=(249,1)", pos_y, dir_y); end end
          500: begin checks++; if (pos_y !== 10'd0 || dir_y !== 1'b1) begin failures++; $display("FAIL top_reach got=(%0d,%0d) exp=(0,1)", pos_y, dir_y); end end
          501: begin checks++; if (pos_y !== 10'd1 || dir_y !== 1'b0) begin failures++; $display("FAIL top_bounce got=(%0d,%0d) exp=(1,0)", pos_y, dir_y); end end
          619: begin checks++; if (pos_x !== 10'd619 || dir_x !== 1'b0) begin failures++; $display("FAIL right_reach got=(%0d,%0d) exp=(619,0)", pos_x, dir_x); end end
          620: begin checks++; if (pos_x !== 10'd618 || dir_x !== 1'b1) begin failures++; $display("FAIL right_bounce got=(%0d,%0d) exp=(618,1)", pos_x, dir_x); end end
          1238: begin checks++; if (pos_x !== 10'd0 || dir_x !== 1'b1) begin failures++; $display("FAIL left_reach got=(%0d,%0d) exp=(0,1)", pos_x, dir_x); end end
          1239: begin checks++; if (pos_x !== 10'd1 || dir_x !== 1'b0) begin failures++; $display("FAIL left_bounce got=(%0d,%0d) exp=(1,0)", pos_x, dir_x); end end
          default: ;
        endcase
      end
    end
    checks++; if (m_moves < 1240) begin failures++; $display("FAIL bounce_budget got=%0d moves exp=1240", m_moves); end
  endtask

  task automatic test_pixel_random();
    int x, y;
    repeat (400) begin
      x = m_pos_x + int'($urandom_range(0, IMG_W + 6)) - 3;
      y = m_pos_y + int'($urandom_range(0, IMG_H + 6)) - 3;
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      cyc(1'b0, 1'b0, 1'b1, ($urandom_range(0, 4) != 0), x, y);
      checks++; if (int'(x_img) !== e_x_img || int'(y_img) !== e_y_img) begin failures++; $display("FAIL rnd_addr got=(%0d,%0d) exp=(%0d,%0d)", x_img, y_img, e_x_img, e_y_img); end
      checks++; if (pixel_out !== e3) begin failures++; $display("FAIL rnd_pixel got=%0d exp=%0d", pixel_out, e3); end
    end
  endtask

  task automatic test_reset_mid_move();
    if (m_acc % FPM == 0) begin cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 0); settle(); end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);   // accepted, second tick of the pair
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);   // COUNT -> MOVE_X
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);   // reset sampled in MOVE_X
    checks++; if (pos_x !== 10'd0 || pos_y !== 10'd0 || dir_x !== 1'b0 || dir_y !== 1'b0) begin failures++; $display("FAIL rst_move got=(%0d,%0d,%0d,%0d) exp=(0,0,0,0)", pos_x, pos_y, dir_x, dir_y); end
    idle(3);
    checks++; if (pos_x !== 10'd0 || pos_y !== 10'd0) begin failures++; $display("FAIL rst_no_partial got=(%0d,%0d) exp=(0,0)", pos_x, pos_y); end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 0); settle();
    checks++; if (pos_x !== 10'd0 || pos_y !== 10'd0) begin failures++; $display("FAIL rst_cnt_clear got=(%0d,%0d) exp=(0,0)", pos_x, pos_y); end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 0); settle();
    checks++; if (pos_x !== 10'd1 || pos_y !== 10'd1) begin failures++; $display("FAIL rst_resume got=(%0d,%0d) exp=(1,1)", pos_x, pos_y); end
  endtask

  task automatic test_tick_in_move_y();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 0); settle();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);   // WAIT -> COUNT
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);   // COUNT -> MOVE_X
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);   // MOVE_X
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);   // tick during MOVE_Y
    settle();
    checks++; if (pos_x !== 10'd2 || pos_y !== 10'd2) begin failures++; $display("FAIL movey_pos got=(%0d,%0d) exp=(2,2)", pos_x, pos_y); end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 0); settle();
    checks++; if (pos_x !== 10'd2 || pos_y !== 10'd2) begin failures++; $display("FAIL movey_dropped got=(%0d,%0d) exp=(2,2)", pos_x, pos_y); end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 0); settle();
    checks++; if (int'(pos_x) !== m_pos_x || pos_x !== 10'd3 || pos_y !== 10'd3) begin failures++; $display("FAIL movey_next got=(%0d,%0d) exp=(3,3)", pos_x, pos_y); end
  endtask

  task automatic test_reset_mid_frame();
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1, m_pos_x + 5, m_pos_y + 7);
    checks++; if (pixel_out !== 1'b1) begin failures++; $display("FAIL frame_pix_on got=%0d exp=1", pixel_out); end
    cyc(1'b1, 1'b0, 1'b1, 1'b1, m_pos_x + 5, m_pos_y + 7);
    checks++; if (pixel_out !== 1'b0 || x_img !== 8'hFF) begin failures++; $display("FAIL frame_rst got=(%0d,%0h) exp=(0,ff)", pixel_out, x_img); end
    repeat (3) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      checks++; if (pixel_out !== e3 || pixel_out !== 1'b0) begin failures++; $display("FAIL frame_after_rst got=%0d exp=0", pixel_out); end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; px_active = 1'b0; frame_tick = 1'b0;
    pixel_in = 1'b0; px_x = 10'd0; px_y = 10'd0;
    test_reset();
    test_address_map();
    test_motion_rate();
    test_bounce_random();
    test_pixel_random();
    test_reset_mid_move();
    test_tick_in_move_y();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
